// File: rtl/mem_dma_pkg.sv
// rtl/mem_dma_pkg.sv - shared types and memory geometry for the DMA copy controller
//
// Purpose: state encoding and banked-memory constants used by mem_dma_ctrl
//          and mem_range_chk.
// Ports:   none (package).
package mem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned BANK_COUNT  = 4;
  localparam int unsigned BANK_ADDR_W = 16;
  // 4 banks x 65536 words = 0x40000 words of addressable memory.
  localparam int unsigned MEM_WORDS   = BANK_COUNT << BANK_ADDR_W;

endpackage

// File: rtl/mem_range_chk.sv
// rtl/mem_range_chk.sv - checks that a word range fits inside the banked memory
//
// Purpose: combinational range check, valid when addr + length - 1 < MEM_WORDS.
// Ports:   addr   (in,  N)     first word address of the range
//          length (in,  LEN_W) number of words in the range (non-zero for a meaningful result)
//          valid  (out, 1)     range lies entirely inside memory
module mem_range_chk
  import mem_dma_pkg::*;
#(
  parameter int N     = 32,
  parameter int LEN_W = 16
) (
  input  logic [N-1:0]     addr,
  input  logic [LEN_W-1:0] length,
  output logic             valid
);

  // One extra bit so a range ending past 2^N cannot wrap back into memory.
  logic [N:0] w_last;

  assign w_last = {1'b0, addr} + (N+1)'(length) - (N+1)'(1);
  assign valid  = (w_last < (N+1)'(MEM_WORDS));

endmodule

// File: rtl/mem_dma_ctrl.sv
// rtl/mem_dma_ctrl.sv - word-by-word memory copy engine sharing memory with a processor
//
// Purpose: copies length words from src_addr to dst_addr, one read and one
//          write cycle per word; the processor (cpu_req) always has priority
//          and simply freezes the engine while it holds the memory.
// Ports:   clk, rst_n                    clock, async active-low reset
//          start, src_addr, dst_addr,
//          length                        copy request, sampled only in IDLE
//          cpu_req                       processor wants the memory this cycle
//          dma_grant                     engine owns the memory port (drives external mux)
//          mem_we, mem_addr, mem_wdata   memory request
//          mem_rdata                     combinational read data for mem_addr
//          busy, done, err               status: busy outside IDLE, done pulse, sticky range error
module mem_dma_ctrl
  import mem_dma_pkg::*;
#(
  parameter int N     = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     src_addr,
  input  logic [N-1:0]     dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             cpu_req,
  output logic             dma_grant,
  output logic             mem_we,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_wdata,
  input  logic [N-1:0]     mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           r_state;
  logic [N-1:0]     r_src;
  logic [N-1:0]     r_dst;
  logic [N-1:0]     r_data;
  logic [LEN_W-1:0] r_count;
  logic             r_err;

  logic             w_src_ok;
  logic             w_dst_ok;
  logic             w_active;

  mem_range_chk #(.N(N), .LEN_W(LEN_W)) u_src_chk (
    .addr   (src_addr),
    .length (length),
    .valid  (w_src_ok)
  );

  mem_range_chk #(.N(N), .LEN_W(LEN_W)) u_dst_chk (
    .addr   (dst_addr),
    .length (length),
    .valid  (w_dst_ok)
  );

  assign w_active = (r_state == READ) || (r_state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              r_err   <= 1'b0;
              r_state <= DONE;
            end else if (w_src_ok && w_dst_ok) begin
              r_src   <= src_addr;
              r_dst   <= dst_addr;
              r_count <= length;
              r_err   <= 1'b0;
              r_state <= READ;
            end else begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        // While cpu_req is high the processor owns the port: hold everything.
        READ: begin
          if (!cpu_req) begin
            r_data  <= mem_rdata;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (!cpu_req) begin
            // Bank crossings are plain increments; bank is just addr[17:16].
            r_src   <= r_src + N'(1);
            r_dst   <= r_dst + N'(1);
            r_count <= r_count - LEN_W'(1);
            r_state <= (r_count == LEN_W'(1)) ? DONE : READ;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Grant and write enable must drop in the same cycle cpu_req rises, so
  // they are decoded from the state register rather than registered.
  assign dma_grant = w_active && !cpu_req;
  assign mem_we    = (r_state == WRITE) && !cpu_req;
  assign mem_addr  = (r_state == READ)  ? r_src :
                     (r_state == WRITE) ? r_dst : '0;
  assign mem_wdata = (r_state == WRITE) ? r_data : '0;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign err       = r_err;

endmodule

// File: tb/tb_mem_dma_ctrl.sv
// tb/tb_mem_dma_ctrl.sv - scoreboard bench for mem_dma_ctrl
module tb_mem_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] length;
  logic        cpu_req;
  logic        dma_grant;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
  } done_t;

  acc_t  exp_acc[$];
  done_t exp_done[$];

  mem_dma_ctrl #(.N(32), .LEN_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .cpu_req   (cpu_req),
    .dma_grant (dma_grant),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source memory content is a fixed function of the address.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
  endfunction

  assign mem_rdata = pat(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: pops expected accesses / done events as the DUT presents them.
  always @(negedge clk) begin
    acc_t  a;
    done_t d;
    if (rst_n) begin
      if (cpu_req) begin
        chk("stall_grant", {31'b0, dma_grant}, 32'd0);
        chk("stall_we", {31'b0, mem_we}, 32'd0);
      end
      if (mem_we) chk("we_has_grant", {31'b0, dma_grant}, 32'd1);
      if (dma_grant) begin
        if (exp_acc.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_access: got we=%0b addr=%h required no access", mem_we, mem_addr);
        end else begin
          a = exp_acc.pop_front();
          chk("acc_we", {31'b0, mem_we}, {31'b0, a.we});
          chk("acc_addr", mem_addr, a.addr);
          if (a.we) chk("acc_wdata", mem_wdata, a.data);
        end
      end
      if (done) begin
        chk("done_idle_we", {31'b0, mem_we}, 32'd0);
        chk("done_idle_addr", mem_addr, 32'd0);
        if (exp_done.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
        end else begin
          d = exp_done.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_err", {31'b0, err}, {31'b0, d.err});
        end
      end
    end
  end

  // Issues a one-cycle start from posedge+1 and pushes the expected
  // accesses (up to max_words words) and, if push_done, the done event.
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                            input int stall, input int max_words, input bit push_done);
    longint unsigned s_end;
    longint unsigned d_end;
    bit              ok;
    int unsigned     k;
    s_end = longint'(s) + longint'(len) - 1;
    d_end = longint'(d) + longint'(len) - 1;
    ok    = (len != 0) && (s_end < 64'h40000) && (d_end < 64'h40000);
    k     = cyc;
    if (ok) begin
      for (int i = 0; i < int'(len) && i < max_words; i++) begin
        exp_acc.push_back('{we: 1'b0, addr: s + 32'(i), data: 32'd0});
        exp_acc.push_back('{we: 1'b1, addr: d + 32'(i), data: pat(s + 32'(i))});
      end
    end
    if (push_done) begin
      if (ok) exp_done.push_back('{cyc: k + 2 * 32'(len) + 1 + 32'(stall), err: 1'b0});
      else    exp_done.push_back('{cyc: k + 1, err: (len != 0)});
    end
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    length   = len;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((busy || exp_done.size() != 0) && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (i >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: got busy=%0b after 100 cycles required idle", busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    cpu_req  = 1'b0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_grant", {31'b0, dma_grant}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic copy: done 7 cycles after start.
    start_copy(32'h0001_0, 32'h1_0020, 16'd3, 0, 100, 1'b1);
    wait_idle();

    // Bank crossing on the source side.
    start_copy(32'h0_FFFF, 32'h2_0000, 16'd2, 0, 100, 1'b1);
    wait_idle();

    // Range error, sticky until the next accepted start.
    start_copy(32'h0000_0100, 32'h3_FFFF, 16'd2, 0, 100, 1'b1);
    wait_idle();
    chk("err_sticky", {31'b0, err}, 32'd1);
    // Last word at 0x3FFFF is still in range.
    start_copy(32'h0000_0200, 32'h3_FFFE, 16'd2, 0, 100, 1'b1);
    chk("err_cleared", {31'b0, err}, 32'd0);
    wait_idle();

    // Processor stall for 4 cycles during the first WRITE.
    start_copy(32'h0000_0300, 32'h3_0300, 16'd2, 4, 100, 1'b1);
    @(posedge clk);
    #1;
    cpu_req = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0;
    wait_idle();

    // Zero length: done next cycle, no access, no error.
    start_copy(32'h0000_0700, 32'h0000_0800, 16'd0, 0, 100, 1'b1);
    wait_idle();

    // Start while busy must be ignored (its range would also flag err).
    start_copy(32'h0000_0400, 32'h2_0400, 16'd3, 0, 100, 1'b1);
    @(posedge clk);
    #1;
    start    = 1'b1;
    src_addr = 32'h0000_0500;
    dst_addr = 32'h3_FFFF;
    length   = 16'd5;
    @(posedge clk);
    #1;
    start    = 1'b0;
    wait_idle();
    chk("busy_start_err", {31'b0, err}, 32'd0);

    // Async reset between edges after the first word was written.
    start_copy(32'h0000_0100, 32'h2_0100, 16'd4, 0, 1, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_grant", {31'b0, dma_grant}, 32'd0);
    chk("arst_we", {31'b0, mem_we}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    chk("acc_queue_empty", exp_acc.size(), 32'd0);
    chk("done_queue_empty", exp_done.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
